// File: rtl/ret_addr_stack_pkg.sv
// Shared CPU package: types and constants for the return-address stack.
// Any unit that configures or checks the overflow policy uses these types.
package ret_addr_stack_pkg;

  typedef enum logic {
    OVF_SAT  = 1'b0,
    OVF_WRAP = 1'b1
  } ovf_mode_e;

  localparam int RAS_DEFAULT_WIDTH = 12;
  localparam int RAS_DEFAULT_DEPTH = 8;

endpackage

// File: rtl/ret_addr_stack_storage.sv
// Storage array for the return-address stack (ras_storage).
// It has one synchronous write port and one combinational read port. It has no reset.
module ras_storage #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/ret_addr_stack.sv
// Return-address stack: a circular pointer and a count over ras_storage.
// It has a {ptr, count} checkpoint for branch-flush recovery and sticky overflow/underflow flags.
module ret_addr_stack
  import ret_addr_stack_pkg::*;
#(
  parameter int        WIDTH    = RAS_DEFAULT_WIDTH,
  parameter int        DEPTH    = RAS_DEFAULT_DEPTH,
  parameter ovf_mode_e OVF_MODE = OVF_SAT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       ckptSave,
  input  logic                       ckptRestore,
  input  logic                       clrErr,
  output logic [WIDTH-1:0]           topData,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]    ptr, ptrNext, ckptPtr, topIdx, wrAddr;
  logic [CW-1:0]    cnt, cntNext, ckptCnt;
  logic             wrEn, ovfEvt, udfEvt;
  logic [WIDTH-1:0] rdData;

  // ptr points at the next free slot. The top entry sits one slot below it, modulo DEPTH.
  assign topIdx  = ptr - 1'b1;
  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign topData = empty ? '0 : rdData;

  always_comb begin
    ptrNext = ptr;
    cntNext = cnt;
    wrEn    = 1'b0;
    wrAddr  = ptr;
    ovfEvt  = 1'b0;
    udfEvt  = 1'b0;
    if (ckptRestore) begin
      ptrNext = ckptPtr;
      cntNext = ckptCnt;
    end else if (push && pop && !empty) begin
      // A call and a return in the same cycle replace the top entry.
      wrEn   = 1'b1;
      wrAddr = topIdx;
    end else if (push) begin
      if (!full) begin
        wrEn    = 1'b1;
        ptrNext = ptr + 1'b1;
        cntNext = cnt + 1'b1;
      end else begin
        ovfEvt = 1'b1;
        if (OVF_MODE == OVF_WRAP) begin
          // When full, ptr also addresses the oldest entry, so the new address overwrites it.
          wrEn    = 1'b1;
          ptrNext = ptr + 1'b1;
        end
      end
    end else if (pop) begin
      if (!empty) begin
        ptrNext = topIdx;
        cntNext = cnt - 1'b1;
      end else begin
        udfEvt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr       <= '0;
      cnt       <= '0;
      ckptPtr   <= '0;
      ckptCnt   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      ptr <= ptrNext;
      cnt <= cntNext;
      if (ckptSave && !ckptRestore) begin
        ckptPtr <= ptr;
        ckptCnt <= cnt;
      end
      // If an error event and clrErr occur in the same cycle, the error event wins.
      overflow  <= ovfEvt | (overflow & ~clrErr);
      underflow <= udfEvt | (underflow & ~clrErr);
    end
  end

  ras_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_storage (
    .clk    (clk),
    .wrEn   (wrEn & rst),
    .wrAddr (wrAddr),
    .wrData (pushData),
    .rdAddr (topIdx),
    .rdData (rdData)
  );

endmodule

// File: tb/tb_ret_addr_stack.sv
// Randomized, model-checked bench for ret_addr_stack.
// Two instances (saturating and wrapping) run from one shared stimulus stream.
module tb_ret_addr_stack;
  import ret_addr_stack_pkg::*;

  localparam int W = 12;
  localparam int D = 4;
  localparam int CW = $clog2(D+1);

  logic clk = 1'b0;
  logic rst, push, pop, ckptSave, ckptRestore, clrErr;
  logic [W-1:0] pushData;

  logic [W-1:0]  topS, topW;
  logic [CW-1:0] cntS, cntW;
  logic emptyS, emptyW, fullS, fullW, ovfS, ovfW, udfS, udfW;

  int total = 0;
  int bad = 0;
  bit chkEn = 0;

  // Behavioural model: index 0 is the saturating instance and index 1 is the wrapping instance.
  int mMem [2][D];
  int mPtr [2], mCnt [2], mCp [2], mCc [2];
  bit mOvf [2], mUdf [2];

  always #5 clk = ~clk;

  ret_addr_stack #(.WIDTH(W), .DEPTH(D), .OVF_MODE(OVF_SAT)) dutS (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .pushData(pushData),
    .ckptSave(ckptSave), .ckptRestore(ckptRestore), .clrErr(clrErr),
    .topData(topS), .count(cntS), .empty(emptyS), .full(fullS),
    .overflow(ovfS), .underflow(udfS));

  ret_addr_stack #(.WIDTH(W), .DEPTH(D), .OVF_MODE(OVF_WRAP)) dutW (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .pushData(pushData),
    .ckptSave(ckptSave), .ckptRestore(ckptRestore), .clrErr(clrErr),
    .topData(topW), .count(cntW), .empty(emptyW), .full(fullW),
    .overflow(ovfW), .underflow(udfW));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int modelTop(input int m);
    return (mCnt[m] == 0) ? 0 : mMem[m][(mPtr[m] + D - 1) % D];
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      bit ovfEv, udfEv;
      ovfEv = 0;
      udfEv = 0;
      if (!rst) begin
        mPtr[m] = 0; mCnt[m] = 0; mCp[m] = 0; mCc[m] = 0; mOvf[m] = 0; mUdf[m] = 0;
      end else begin
        if (ckptRestore) begin
          mPtr[m] = mCp[m];
          mCnt[m] = mCc[m];
        end else begin
          if (ckptSave) begin
            mCp[m] = mPtr[m];
            mCc[m] = mCnt[m];
          end
          if (push && pop && mCnt[m] > 0) begin
            mMem[m][(mPtr[m] + D - 1) % D] = int'(pushData);
          end else if (push) begin
            if (mCnt[m] < D) begin
              mMem[m][mPtr[m]] = int'(pushData);
              mPtr[m] = (mPtr[m] + 1) % D;
              mCnt[m]++;
            end else begin
              ovfEv = 1;
              if (m == 1) begin
                mMem[m][mPtr[m]] = int'(pushData);
                mPtr[m] = (mPtr[m] + 1) % D;
              end
            end
          end else if (pop) begin
            if (mCnt[m] > 0) begin
              mPtr[m] = (mPtr[m] + D - 1) % D;
              mCnt[m]--;
            end else begin
              udfEv = 1;
            end
          end
        end
        mOvf[m] = ovfEv ? 1'b1 : (clrErr ? 1'b0 : mOvf[m]);
        mUdf[m] = udfEv ? 1'b1 : (clrErr ? 1'b0 : mUdf[m]);
      end
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      chk("S.top", 32'(topS), modelTop(0));
      chk("S.count", 32'(cntS), mCnt[0]);
      chk("S.empty", 32'(emptyS), 32'(mCnt[0] == 0));
      chk("S.full", 32'(fullS), 32'(mCnt[0] == D));
      chk("S.ovf", 32'(ovfS), 32'(mOvf[0]));
      chk("S.udf", 32'(udfS), 32'(mUdf[0]));
      chk("W.top", 32'(topW), modelTop(1));
      chk("W.count", 32'(cntW), mCnt[1]);
      chk("W.empty", 32'(emptyW), 32'(mCnt[1] == 0));
      chk("W.full", 32'(fullW), 32'(mCnt[1] == D));
      chk("W.ovf", 32'(ovfW), 32'(mOvf[1]));
      chk("W.udf", 32'(udfW), 32'(mUdf[1]));
    end
  end

  // Drives one cycle of stimulus, starting and returning at a falling edge.
  task automatic cyc(input bit r, input bit pu, input bit po, input int d,
                     input bit sv, input bit rs, input bit ce);
    rst = r; push = pu; pop = po; pushData = W'(d);
    ckptSave = sv; ckptRestore = rs; clrErr = ce;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doPush(input int d); cyc(1, 1, 0, d, 0, 0, 0); endtask
  task automatic doPop();             cyc(1, 0, 1, 0, 0, 0, 0); endtask
  task automatic doReset();           cyc(0, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    rst = 0; push = 0; pop = 0; pushData = '0; ckptSave = 0; ckptRestore = 0; clrErr = 0;
    @(negedge clk);
    doReset();
    chkEn = 1;
    doReset();
    chk("rst.count", 32'(cntS), 0);
    chk("rst.top", 32'(topS), 0);
    chk("rst.empty", 32'(emptyS), 1);

    // Sequence 1: push three addresses, then pop back down to empty.
    doPush('h010); doPush('h020); doPush('h030);
    chk("lifo.count", 32'(cntS), 3);
    chk("lifo.top", 32'(topS), 'h030);
    doPop(); chk("lifo.pop1", 32'(topS), 'h020);
    doPop(); chk("lifo.pop2", 32'(topS), 'h010);
    doPop(); chk("lifo.pop3", 32'(topS), 0);
    chk("lifo.empty", 32'(emptyS), 1);

    // Sequence 2: overflow under each policy, then clear the errors and drain the wrapping instance.
    doReset();
    for (int i = 1; i <= 5; i++) doPush(i);
    chk("sat.full", 32'(fullS), 1);
    chk("sat.ovf", 32'(ovfS), 1);
    chk("sat.count", 32'(cntS), 4);
    chk("sat.top", 32'(topS), 'h004);
    chk("wrap.count", 32'(cntW), 4);
    chk("wrap.top", 32'(topW), 'h005);
    chk("wrap.ovf", 32'(ovfW), 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("sat.clrErr", 32'(ovfS), 0);
    doPop(); chk("wrap.pop1", 32'(topW), 'h004);
    doPop(); chk("wrap.pop2", 32'(topW), 'h003);
    doPop(); chk("wrap.pop3", 32'(topW), 'h002);
    doPop(); chk("wrap.empty", 32'(emptyW), 1);

    // Sequence 3: a simultaneous push and pop replaces the top entry; a pop while empty sets underflow.
    doReset();
    doPush('h100);
    cyc(1, 1, 1, 'h200, 0, 0, 0);
    chk("pp.count", 32'(cntS), 1);
    chk("pp.top", 32'(topS), 'h200);
    doPop(); doPop();
    chk("udf.flag", 32'(udfS), 1);
    chk("udf.count", 32'(cntS), 0);

    // Sequence 4: restore from a checkpoint while a push is also asserted.
    doReset();
    doPush('h0A0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    doPush('h0B0); doPush('h0C0);
    cyc(1, 1, 0, 'h0D0, 0, 1, 0);
    chk("ckpt.count", 32'(cntS), 1);
    chk("ckpt.top", 32'(topS), 'h0A0);

    // Sequence 5: reset wins over a simultaneous push and restore.
    doPop(); doPop(); doPush('h0E0);
    cyc(0, 1, 0, 'h0F0, 0, 1, 0);
    chk("rstwin.count", 32'(cntS), 0);
    chk("rstwin.udf", 32'(udfS), 0);
    chk("rstwin.ovf", 32'(ovfS), 0);
    chk("rstwin.top", 32'(topS), 0);

    // Random traffic, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) != 0,
          $urandom_range(0, 99) < 45,
          $urandom_range(0, 99) < 40,
          int'($urandom_range(0, (1 << W) - 1)),
          $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 6,
          $urandom_range(0, 99) < 8);
    end

    chkEn = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ret_addr_stack.md
RET_ADDR_STACK -- requirements
Module: ret_addr_stack

Interface
REQ-001 Parameter: WIDTH, 12, bit width of each stored return address (matches the 12-bit PC).
REQ-002 Parameter: DEPTH, 8, number of entries; power of two, minimum 2.
REQ-003 Parameter: OVF_MODE, OVF_SAT, overflow policy (OVF_SAT rejects the push; OVF_WRAP overwrites the oldest entry).
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  in  1  reset; synchronous, active-low.
REQ-006 Port: push  in  1  push pushData this cycle.
REQ-007 Port: pop  in  1  pop the top entry this cycle.
REQ-008 Port: pushData  in  WIDTH  address to push (PC+1 of the call).
REQ-009 Port: ckptSave  in  1  snapshot the pointer and count.
REQ-010 Port: ckptRestore  in  1  restore the pointer and count from the snapshot (pipeline flush).
REQ-011 Port: clrErr  in  1  clear the sticky error flags.
REQ-012 Port: topData  out  WIDTH  current top entry; 0 when empty.
REQ-013 Port: count  out  $clog2(DEPTH+1)  number of valid entries.
REQ-014 Port: empty  out  1  count == 0.
REQ-015 Port: full  out  1  count == DEPTH.
REQ-016 Port: overflow  out  1  sticky; set by a push while full.
REQ-017 Port: underflow  out  1  sticky; set by a pop while empty.

Function
REQ-018 topData, count, empty and full shall be combinational from registered state, so each edge is visible in the same cycle (zero added latency).
REQ-019 Push only, not full: write mem[ptr], then ptr+1 mod DEPTH and count+1.
REQ-020 Push only, full, OVF_SAT: no state change; set overflow.
REQ-021 Push only, full, OVF_WRAP: write mem[ptr] (the oldest entry), then ptr+1 mod DEPTH; count stays DEPTH; set overflow.
REQ-022 Pop only, not empty: ptr-1 mod DEPTH, count-1; memory unchanged.
REQ-023 Pop only, empty: no state change; set underflow.
REQ-024 Push and pop together, not empty: overwrite mem[ptr-1] with pushData; ptr and count unchanged; no flag set, even when full.
REQ-025 Push and pop together, empty: act as push only; underflow not set.
REQ-026 ckptSave: latch {ptr, count} into the checkpoint register; a push or pop in the same cycle proceeds, and the pre-update values are saved.
REQ-027 ckptRestore: load {ptr, count} from the checkpoint; push, pop and ckptSave in the same cycle are ignored; memory contents are not restored.
REQ-028 clrErr: clear overflow and underflow; an error event in the same cycle wins, so that flag is set.
REQ-029 Pointer arithmetic shall wrap modulo DEPTH; count shall never exceed DEPTH or go below 0.

Reset
REQ-030 While rst is low at a rising edge, the block shall set ptr=0, count=0, checkpoint=0, overflow=0, underflow=0; push, pop, ckpt and clrErr are ignored.
REQ-031 Memory contents shall not be reset; topData shall be 0 after reset because the stack is empty.
REQ-032 Reset asserted mid-sequence (including in the same cycle as a restore) shall win over every other input.

Structure
REQ-033 The overflow-mode enum (OVF_SAT, OVF_WRAP) shall live in the shared CPU package.
REQ-034 Storage shall be one sub-module, ras_storage: DEPTH x WIDTH registers, one synchronous write port and one combinational read port, with no reset.
REQ-035 Pointer, count, checkpoint and flag logic shall sit in ret_addr_stack.

Verification (DEPTH=4, WIDTH=12)
REQ-036 Bench: reset, push 0x010, 0x020, 0x030 -> count=3, topData=0x030; pop x3 -> topData 0x020, 0x010, then 0 with empty=1.
REQ-037 Bench: OVF_SAT, push 0x001..0x005 -> full=1, overflow=1, count=4, topData=0x004; clrErr -> overflow=0.
REQ-038 Bench: OVF_WRAP, push 0x001..0x005 -> count=4, topData=0x005, overflow=1; 4 pops -> 0x004, 0x003, 0x002, then empty.
REQ-039 Bench: push 0x100; push+pop 0x200 -> count=1, topData=0x200; pop on empty -> underflow=1, count=0.
REQ-040 Bench: push 0x0A0; ckptSave; push 0x0B0, 0x0C0; ckptRestore with push 0x0D0 asserted -> count=1, topData=0x0A0.
REQ-041 Bench: rst low in the same cycle as push and ckptRestore -> count=0, flags=0, topData=0.
